// File: rtl/timer_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : timer_tick_scheduler
// Purpose  : Avalon-MM write-only master for a 16-bit-register interval timer.
//            Programs the timer period/control, clears its interrupt, turns
//            every timeout into a system tick (free-running tick_count_o) and
//            multiplexes NUM_CH software alarm channels onto that tick.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk_i, reset_i           clock, asynchronous active-high reset
//            avm_*_o                  registered Avalon-MM master write port
//            timer_irq_i              timer interrupt (level)
//            cfg_period_i/cfg_load_i  request a timer reprogram
//            ch_arm_i/ch_cancel_i     per-channel arm / cancel pulses
//            ch_delay_i               16 bits per channel, delay in ticks
//            ch_periodic_i            per-channel periodic mode
//            ch_active_o/ch_alarm_o   channel armed / one-cycle alarm pulse
//            tick_count_o             ticks since reset (wraps at 2^32)
//            busy_o                   controller not idle in RUN
// Options  : define TICK_SCHED_PERIODIC_EN to build per-channel delay latches
//            and honour ch_periodic_i; otherwise every channel is one-shot.
// ============================================================================
module timer_tick_scheduler #(
  parameter int          NUM_CH     = 4,
  parameter logic [31:0] DEF_PERIOD = 32'd49999
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  output logic [2:0]             avm_address_o,
  output logic                   avm_chipselect_o,
  output logic                   avm_write_n_o,
  output logic [15:0]            avm_writedata_o,
  input  logic                   timer_irq_i,
  input  logic [31:0]            cfg_period_i,
  input  logic                   cfg_load_i,
  input  logic [NUM_CH-1:0]      ch_arm_i,
  input  logic [NUM_CH-1:0]      ch_cancel_i,
  input  logic [16*NUM_CH-1:0]   ch_delay_i,
  input  logic [NUM_CH-1:0]      ch_periodic_i,
  output logic [NUM_CH-1:0]      ch_active_o,
  output logic [NUM_CH-1:0]      ch_alarm_o,
  output logic [31:0]            tick_count_o,
  output logic                   busy_o
);

  localparam logic [2:0]  c_ADDR_STATUS = 3'd0;
  localparam logic [2:0]  c_ADDR_CTRL   = 3'd1;
  localparam logic [2:0]  c_ADDR_PER_L  = 3'd2;
  localparam logic [2:0]  c_ADDR_PER_H  = 3'd3;
  localparam logic [15:0] c_CTRL_RUN    = 16'h0007;  // ITO | CONT | START

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_WR_PL   = 3'd1,
    S_WR_PH   = 3'd2,
    S_WR_CTRL = 3'd3,
    S_RUN     = 3'd4,
    S_CLR     = 3'd5,
    S_TICK    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic        pend_q, pend_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [31:0] tick_q;
  logic        w_tick;

  // Next state plus the bus cycle belonging to that state: the bus registers
  // are loaded on the same edge that enters the state, so each write is
  // visible for exactly the one cycle the FSM spends there.
  always_comb begin
    state_d  = state_q;
    cs_d     = 1'b0;
    wn_d     = 1'b1;
    addr_d   = 3'd0;
    data_d   = 16'h0000;
    shadow_d = shadow_q;
    pend_d   = pend_q;

    case (state_q)
      S_INIT:    state_d = S_WR_PL;
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_RUN;
      S_RUN: begin
        // Interrupt service has priority over a pending reprogram.
        if (timer_irq_i)  state_d = S_CLR;
        else if (pend_q)  state_d = S_WR_PL;
      end
      S_CLR:     state_d = S_TICK;
      S_TICK:    state_d = S_RUN;
      default:   state_d = S_INIT;
    endcase

    case (state_d)
      S_WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = c_ADDR_PER_L; data_d = shadow_q[15:0];
      end
      S_WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = c_ADDR_PER_H; data_d = shadow_q[31:16];
      end
      S_WR_CTRL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = c_ADDR_CTRL; data_d = c_CTRL_RUN;
      end
      S_CLR: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = c_ADDR_STATUS; data_d = 16'h0000;
      end
      default: ;
    endcase

    // A load arriving on the very edge that starts a reprogram keeps the
    // request pending, so the newest period is always written eventually.
    if (state_d == S_WR_PL) pend_d = 1'b0;
    if (cfg_load_i) begin
      shadow_d = cfg_period_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_INIT;
      shadow_q <= DEF_PERIOD;
      pend_q   <= 1'b0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      addr_q   <= 3'd0;
      data_q   <= 16'h0000;
      tick_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      if (w_tick) tick_q <= tick_q + 32'd1;
    end
  end

  // All tick side effects land on the clock edge that ends the TICK cycle.
  assign w_tick = (state_q == S_TICK);

  assign avm_chipselect_o = cs_q;
  assign avm_write_n_o    = wn_q;
  assign avm_address_o    = addr_q;
  assign avm_writedata_o  = data_q;
  assign tick_count_o     = tick_q;
  assign busy_o           = (state_q != S_RUN);

`ifndef TICK_SCHED_PERIODIC_EN
  logic w_unused_periodic;
  assign w_unused_periodic = ^ch_periodic_i;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [15:0] cnt_q, cnt_d;
    logic        act_q, act_d;
    logic        alm_q, alm_d;
    logic [15:0] w_delay;

    assign w_delay = ch_delay_i[16*i +: 16];

`ifdef TICK_SCHED_PERIODIC_EN
    logic [15:0] dly_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)          dly_q <= 16'h0000;
      else if (ch_arm_i[i]) dly_q <= w_delay;
    end
`endif

    // Priority: arm > cancel > tick. A count of d therefore alarms on the
    // (d+1)th tick after arming.
    always_comb begin
      cnt_d = cnt_q;
      act_d = act_q;
      alm_d = 1'b0;
      if (ch_arm_i[i]) begin
        cnt_d = w_delay;
        act_d = 1'b1;
      end else if (ch_cancel_i[i]) begin
        act_d = 1'b0;
      end else if (w_tick && act_q) begin
        if (cnt_q == 16'd0) begin
          alm_d = 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
          if (ch_periodic_i[i]) cnt_d = dly_q;
          else                  act_d = 1'b0;
`else
          act_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_q <= 16'h0000;
        act_q <= 1'b0;
        alm_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        act_q <= act_d;
        alm_q <= alm_d;
      end
    end

    assign ch_active_o[i] = act_q;
    assign ch_alarm_o[i]  = alm_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_tick_scheduler
// Purpose  : Self-checking bench for timer_tick_scheduler. A behavioural model
//            (queue of pending bus actions, absolute due-tick per channel)
//            predicts every output each cycle; directed sections pin the
//            model with hand-computed literals, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_tick_scheduler;

  localparam int          NUM_CH     = 4;
  localparam logic [31:0] DEF_PERIOD = 32'd49999;
`ifdef TICK_SCHED_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           avm_address;
  logic                 avm_chipselect, avm_write_n;
  logic [15:0]          avm_writedata;
  logic                 timer_irq = 1'b0;
  logic [31:0]          cfg_period = 32'd0;
  logic                 cfg_load = 1'b0;
  logic [NUM_CH-1:0]    ch_arm = '0, ch_cancel = '0, ch_periodic = '0;
  logic [16*NUM_CH-1:0] ch_delay = '0;
  logic [NUM_CH-1:0]    ch_active, ch_alarm;
  logic [31:0]          tick_count;
  logic                 busy;

  always #5 clk = ~clk;

  timer_tick_scheduler #(.NUM_CH(NUM_CH), .DEF_PERIOD(DEF_PERIOD)) dut (
    .clk_i(clk), .reset_i(rst),
    .avm_address_o(avm_address), .avm_chipselect_o(avm_chipselect),
    .avm_write_n_o(avm_write_n), .avm_writedata_o(avm_writedata),
    .timer_irq_i(timer_irq), .cfg_period_i(cfg_period), .cfg_load_i(cfg_load),
    .ch_arm_i(ch_arm), .ch_cancel_i(ch_cancel), .ch_delay_i(ch_delay),
    .ch_periodic_i(ch_periodic), .ch_active_o(ch_active), .ch_alarm_o(ch_alarm),
    .tick_count_o(tick_count), .busy_o(busy)
  );

  // ---------------- behavioural model ----------------
  localparam int A_INIT = 0, A_RUN = 1, A_PL = 2, A_PH = 3, A_CTRL = 4, A_CLR = 5, A_TICK = 6;

  int          m_cur, m_nxt;
  int          m_q[$];
  logic [31:0] m_shadow, m_tick, m_nt;
  logic        m_pend, m_tick_now;
  logic [NUM_CH-1:0] m_act, m_alm;
  logic [31:0] m_due [NUM_CH];
  logic [15:0] m_dly [NUM_CH];
  logic        m_cs, m_wn;
  logic [2:0]  m_addr;
  logic [15:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = A_INIT;
      m_q.delete();
      m_q.push_back(A_PL); m_q.push_back(A_PH); m_q.push_back(A_CTRL);
      m_shadow = DEF_PERIOD; m_pend = 1'b0; m_tick = 32'd0;
      m_act = '0; m_alm = '0;
      m_cs = 1'b0; m_wn = 1'b1; m_addr = 3'd0; m_data = 16'h0;
      for (int i = 0; i < NUM_CH; i++) begin m_due[i] = 32'd0; m_dly[i] = 16'd0; end
    end else begin
      m_tick_now = (m_cur == A_TICK);
      if (m_cur == A_RUN && m_q.size() == 0) begin
        if (timer_irq) begin
          m_q.push_back(A_CLR); m_q.push_back(A_TICK);
        end else if (m_pend) begin
          m_q.push_back(A_PL); m_q.push_back(A_PH); m_q.push_back(A_CTRL);
        end
      end
      m_nxt = (m_q.size() != 0) ? m_q.pop_front() : A_RUN;
      m_cs = 1'b0; m_wn = 1'b1; m_addr = 3'd0; m_data = 16'h0;
      case (m_nxt)
        A_PL:   begin m_cs = 1'b1; m_wn = 1'b0; m_addr = 3'd2; m_data = m_shadow[15:0];  end
        A_PH:   begin m_cs = 1'b1; m_wn = 1'b0; m_addr = 3'd3; m_data = m_shadow[31:16]; end
        A_CTRL: begin m_cs = 1'b1; m_wn = 1'b0; m_addr = 3'd1; m_data = 16'h0007;       end
        A_CLR:  begin m_cs = 1'b1; m_wn = 1'b0; m_addr = 3'd0; m_data = 16'h0000;       end
        default: ;
      endcase
      if (m_nxt == A_PL) m_pend = 1'b0;
      if (cfg_load) begin m_shadow = cfg_period; m_pend = 1'b1; end
      m_cur = m_nxt;

      m_nt = m_tick + (m_tick_now ? 32'd1 : 32'd0);
      for (int i = 0; i < NUM_CH; i++) begin
        m_alm[i] = 1'b0;
        if (ch_arm[i]) begin
          m_act[i] = 1'b1;
          m_dly[i] = ch_delay[16*i +: 16];
          m_due[i] = m_nt + {16'd0, m_dly[i]} + 32'd1;
        end else if (ch_cancel[i]) begin
          m_act[i] = 1'b0;
        end else if (m_tick_now && m_act[i] && m_nt == m_due[i]) begin
          m_alm[i] = 1'b1;
          if (PER_EN && ch_periodic[i]) m_due[i] = m_due[i] + {16'd0, m_dly[i]} + 32'd1;
          else                          m_act[i] = 1'b0;
        end
      end
      m_tick = m_nt;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic wr0_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [20:0] bus_now();
    return {avm_chipselect, avm_write_n, avm_address, avm_writedata};
  endfunction

  // One clock step: inputs driven just after the edge, outputs checked
  // against the model, the emulated timer drops its irq after a status write.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (wr0_prev) timer_irq = 1'b0;
    check("bus",    {43'd0, bus_now()}, {43'd0, m_cs, m_wn, m_addr, m_data});
    check("busy",   {63'd0, busy},      {63'd0, m_cur != A_RUN});
    check("tick",   {32'd0, tick_count}, {32'd0, m_tick});
    check("active", {60'd0, ch_active}, {60'd0, m_act});
    check("alarm",  {60'd0, ch_alarm},  {60'd0, m_alm});
    wr0_prev  = avm_chipselect && !avm_write_n && avm_address == 3'd0;
    ch_arm    = '0;
    ch_cancel = '0;
    cfg_load  = 1'b0;
  endtask

  task automatic do_tick();
    timer_irq = 1'b1;
    next_cycle();  // RUN -> CLR
    next_cycle();  // CLR -> TICK
    next_cycle();  // TICK -> RUN
  endtask

  initial begin
    // ---- reset state ----
    next_cycle();
    next_cycle();
    check("rst_busy",  {63'd0, busy},       64'd1);
    check("rst_tick",  {32'd0, tick_count}, 64'd0);
    check("rst_bus",   {43'd0, bus_now()},  {43'd0, 1'b0, 1'b1, 3'd0, 16'h0});
    check("rst_act",   {60'd0, ch_active},  64'd0);
    check("rst_alarm", {60'd0, ch_alarm},   64'd0);
    rst = 1'b0;

    // ---- initial programming ----
    next_cycle(); check("init_pl",   {43'd0, bus_now()}, {43'd0, 1'b1, 1'b0, 3'd2, 16'hC34F});
    next_cycle(); check("init_ph",   {43'd0, bus_now()}, {43'd0, 1'b1, 1'b0, 3'd3, 16'h0000});
    next_cycle(); check("init_ctrl", {43'd0, bus_now()}, {43'd0, 1'b1, 1'b0, 3'd1, 16'h0007});
                  check("init_busy", {63'd0, busy}, 64'd1);
    next_cycle(); check("run_idle",  {43'd0, bus_now()}, {43'd0, 1'b0, 1'b1, 3'd0, 16'h0});
                  check("run_busy",  {63'd0, busy}, 64'd0);

    // ---- single interrupt ----
    timer_irq = 1'b1;
    next_cycle(); check("clr_wr",   {43'd0, bus_now()}, {43'd0, 1'b1, 1'b0, 3'd0, 16'h0});
    next_cycle(); check("tick_pre", {32'd0, tick_count}, 64'd0);
    next_cycle(); check("tick_one", {32'd0, tick_count}, 64'd1);
    repeat (3) next_cycle();
    check("tick_hold", {32'd0, tick_count}, 64'd1);

    // ---- ch0 one-shot, delay 2 ----
    ch_arm[0] = 1'b1; ch_delay[15:0] = 16'd2;
    next_cycle(); check("ch0_armed", {63'd0, ch_active[0]}, 64'd1);
    do_tick();    check("ch0_t1", {62'd0, ch_alarm[0], ch_active[0]}, 64'b01);
    do_tick();    check("ch0_t2", {62'd0, ch_alarm[0], ch_active[0]}, 64'b01);
    do_tick();    check("ch0_t3", {62'd0, ch_alarm[0], ch_active[0]}, 64'b10);
    next_cycle(); check("ch0_once", {63'd0, ch_alarm[0]}, 64'd0);

    // ---- ch1 armed during TICK with delay 0 ----
    timer_irq = 1'b1;
    next_cycle(); next_cycle();
    ch_arm[1] = 1'b1; ch_delay[31:16] = 16'd0;
    next_cycle(); check("ch1_arm_tick", {62'd0, ch_alarm[1], ch_active[1]}, 64'b01);
    do_tick();    check("ch1_next",     {62'd0, ch_alarm[1], ch_active[1]}, 64'b10);

    // ---- ch2 cancelled on its alarming tick ----
    ch_arm[2] = 1'b1; ch_delay[47:32] = 16'd0;
    next_cycle();
    timer_irq = 1'b1;
    next_cycle(); next_cycle();
    ch_cancel[2] = 1'b1;
    next_cycle(); check("ch2_cancel", {62'd0, ch_alarm[2], ch_active[2]}, 64'b00);

    // ---- reprogram coincident with irq ----
    timer_irq = 1'b1; cfg_load = 1'b1; cfg_period = 32'h0001_86A0;
    next_cycle(); check("rp_clr",  {43'd0, bus_now()}, {43'd0, 1'b1, 1'b0, 3'd0, 16'h0});
    next_cycle(); check("rp_tick", {63'd0, busy}, 64'd1);
    next_cycle(); check("rp_run",  {43'd0, bus_now()}, {43'd0, 1'b0, 1'b1, 3'd0, 16'h0});
    next_cycle(); check("rp_pl",   {43'd0, bus_now()}, {43'd0, 1'b1, 1'b0, 3'd2, 16'h86A0});
    next_cycle(); check("rp_ph",   {43'd0, bus_now()}, {43'd0, 1'b1, 1'b0, 3'd3, 16'h0001});
    next_cycle(); check("rp_ctrl", {43'd0, bus_now()}, {43'd0, 1'b1, 1'b0, 3'd1, 16'h0007});
    next_cycle(); check("rp_done", {63'd0, busy}, 64'd0);

`ifdef TICK_SCHED_PERIODIC_EN
    // ---- ch3 periodic, delay 1 ----
    ch_arm[3] = 1'b1; ch_delay[63:48] = 16'd1; ch_periodic[3] = 1'b1;
    next_cycle();
    for (int p = 0; p < 5; p++) begin
      do_tick(); check("per_gap",   {62'd0, ch_alarm[3], ch_active[3]}, 64'b01);
      do_tick(); check("per_alarm", {62'd0, ch_alarm[3], ch_active[3]}, 64'b11);
    end
    ch_cancel[3] = 1'b1;
    next_cycle(); check("per_cancel", {63'd0, ch_active[3]}, 64'd0);
    do_tick(); do_tick();
    check("per_stopped", {63'd0, ch_alarm[3]}, 64'd0);
    ch_periodic[3] = 1'b0;
`endif

    // ---- randomized traffic with one mid-run reset ----
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst = 1'b1; timer_irq = 1'b0;
        next_cycle(); next_cycle();
        rst = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        ch_arm[i]            = ($urandom_range(0, 11) == 0);
        ch_cancel[i]         = ($urandom_range(0, 23) == 0);
        ch_periodic[i]       = $urandom_range(0, 1) == 1;
        ch_delay[16*i +: 16] = 16'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 39) == 0) begin
        cfg_load   = 1'b1;
        cfg_period = $urandom;
      end
      if (!timer_irq && $urandom_range(0, 4) == 0) timer_irq = 1'b1;
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_tick_scheduler.md
Name: timer_tick_scheduler

Overview:
- Avalon-MM master controller for the 16-bit-register interval timer slave. Programs the timer's period and control registers and services its interrupt.
- Turns each timeout into a system tick and drives a free-running tick counter.
- Multiplexes NUM_CH independent software alarm channels onto that single hardware timer.
- Sits between the timer slave and the HW accelerators / CPU-side alarm logic.

Parameters:
- NUM_CH, 4, number of alarm channels (1..8).
- DEF_PERIOD, 32'd49999, period loaded after reset (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avm_address  out  3  timer register address (0 status, 1 control, 2 period_l, 3 period_h).
- avm_chipselect  out  1  timer select.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  16  timer write data.
- timer_irq  in  1  timer interrupt (level).
- cfg_period  in  32  new timer period.
- cfg_load  in  1  pulse: reprogram the timer with cfg_period.
- ch_arm  in  NUM_CH  per-channel arm pulse.
- ch_cancel  in  NUM_CH  per-channel cancel pulse.
- ch_delay  in  16*NUM_CH  per-channel delay in ticks; channel i uses bits [16i+15:16i].
- ch_periodic  in  NUM_CH  per-channel periodic mode (see Optional Feature).
- ch_active  out  NUM_CH  channel armed and counting.
- ch_alarm  out  NUM_CH  one-cycle alarm pulse.
- tick_count  out  32  ticks since the last reset, wraps at 2^32.
- busy  out  1  FSM not in RUN.

Behaviour:
- Reset values:
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - ch_active=0, ch_alarm=0, tick_count=0, busy=1.
  - period shadow = DEF_PERIOD, cfg_pend=0, state=INIT.
- Master bus rules:
  - Writes only; each is a single cycle with chipselect=1 and write_n=0. The slave has no waitrequest.
  - All master outputs are registered.
  - Outside a write: chipselect=0, write_n=1.
- FSM:
  - INIT → WR_PL: write addr 2, data = shadow[15:0].
  - WR_PL → WR_PH: write addr 3, data = shadow[31:16].
  - WR_PH → WR_CTRL: write addr 1, data 0x0007 (ITO, CONT, START).
  - WR_CTRL → RUN.
  - RUN → CLR when timer_irq=1. CLR writes addr 0, data 0.
  - CLR → TICK.
  - TICK → RUN.
  - RUN → WR_PL when cfg_pend=1 and timer_irq=0. Clear cfg_pend on entry to WR_PL.
  - Each state except RUN lasts exactly one cycle.
- Reprogramming:
  - Reprogram latency from cfg_load to the CONT/START write is 4 cycles when idle in RUN.
  - cfg_load in any state: shadow <= cfg_period, cfg_pend <= 1. The last value before the WR_PL entry wins.
  - irq and cfg_pend both present in RUN: irq serviced first; reprogram starts after TICK.
- TICK cycle:
  - tick_count += 1.
  - Every active channel with count != 0 decrements.
  - Every active channel with count == 0 pulses ch_alarm next cycle and clears ch_active (one-shot).
- Channel arm:
  - ch_arm[i] loads count = delay, ch_active[i]=1, in any state.
  - Arm while already active restarts the channel.
  - Delay 0 alarms on the first TICK after arming. Delay d alarms on the (d+1)th TICK.
  - Arm in the same cycle as TICK for that channel: arm wins; no decrement and no alarm.
- Channel cancel:
  - ch_cancel[i] clears ch_active[i]. A pending alarm for that TICK is suppressed.
  - Arm and cancel in the same cycle: arm wins.
- Reset mid-operation returns to INIT and reprograms DEF_PERIOD. A cfg_load pending at reset is lost.

Optional Feature:
- Macro: TICK_SCHED_PERIODIC_EN.
- Defined: when a channel alarms on TICK and ch_periodic[i]=1, it reloads its latched arm delay and stays active. The alarm repeats every (delay+1) ticks until cancelled.
- Undefined: ch_periodic is ignored; all channels are one-shot; no delay latch registers are built.

Test Plan:
- Reset release → write sequence at consecutive cycles: addr2/0xC34F, addr3/0x0000, addr1/0x0007; busy drops the cycle after WR_CTRL.
- Raise timer_irq in RUN → next cycle write addr0/0x0000; tick_count 0→1 one cycle later; drop irq after the clear write; exactly one tick counted.
- Arm ch0 with delay 2 → ch_alarm[0] pulses once, 1 cycle after the 3rd TICK; ch_active[0] falls at the same time.
- Arm ch1 on the same cycle as TICK with delay 0 → no alarm on that tick, alarm after the next tick. Cancel ch2 on its alarming tick → no pulse.
- cfg_load=0x0001_86A0 coincident with timer_irq → CLR/TICK first, then writes 0x86A0, 0x0001, 0x0007.
- With TICK_SCHED_PERIODIC_EN and ch3 periodic, delay 1 → alarms every 2 ticks for 5 periods; ch_cancel stops them.
